// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: synchronise and debounce the crosswalk button,
// latch one request, pulse pass while the light is not green, and enforce a hold-off.
module ped_request_ctrl #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned ACK_TIMEOUT    = 4,
  parameter int unsigned HOLDOFF_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic R,
  input  logic G,
  input  logic Y,
  output logic pass,
  output logic wait_led,
  output logic btn_db
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PENDING = 3'd1,
    ST_GRANT   = 3'd2,
    ST_WAIT_G  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic             r_btn_db;
  logic             r_db_d;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_req_lat;
  logic             r_pass;
  logic             r_wait_led;
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] r_hcnt;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_tcnt_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_press;
  logic             w_req_clr;
  logic             w_req_nxt;
  logic             w_wait_nxt;
  logic             w_unused_ry;

  // R and Y carry no decision weight; only G=0 means "not green".
  assign w_unused_ry = R ^ Y;

  // Synchroniser and debounce: level flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_btn_db  <= 1'b0;
      r_db_d    <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_s1   <= btn;
      r_s2   <= r_s1;
      r_db_d <= r_btn_db;
      if (r_s2 != r_btn_db) begin
        if (r_deb_cnt >= DEB_LAST) begin
          r_btn_db  <= ~r_btn_db;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + CNT_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_press = r_btn_db & ~r_db_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tcnt     <= '0;
      r_hcnt     <= '0;
      r_req_lat  <= 1'b0;
      r_pass     <= 1'b0;
      r_wait_led <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_req_lat  <= w_req_nxt;
      r_pass     <= (w_state_nxt == ST_GRANT);
      r_wait_led <= w_wait_nxt;
    end
  end

  // Next state; WAIT_G counts its own cycles from 1 so a retry comes ACK_TIMEOUT cycles after entry.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_hcnt_nxt  = r_hcnt;
    w_req_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_req_lat) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (G) begin
          w_req_clr   = 1'b1;
          w_hcnt_nxt  = '0;
          w_state_nxt = ST_HOLDOFF;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_tcnt_nxt  = CNT_W'(1);
        w_state_nxt = ST_WAIT_G;
      end
      ST_WAIT_G: begin
        if (G) begin
          w_req_clr   = 1'b1;
          w_hcnt_nxt  = '0;
          w_state_nxt = ST_HOLDOFF;
        end else if (r_tcnt >= ACK_LAST) begin
          w_state_nxt = ST_PENDING;
        end else begin
          w_tcnt_nxt = r_tcnt + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (r_hcnt >= HOLD_LAST) begin
          w_state_nxt = r_req_lat ? ST_PENDING : ST_IDLE;
        end else begin
          w_hcnt_nxt = r_hcnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A new press on the clearing edge wins.
    w_req_nxt  = w_press | (r_req_lat & ~w_req_clr);
    w_wait_nxt = (w_state_nxt == ST_PENDING) || (w_state_nxt == ST_GRANT) ||
                 (w_state_nxt == ST_WAIT_G)  || ((w_state_nxt == ST_HOLDOFF) && w_req_nxt);
  end

  assign pass     = r_pass;
  assign wait_led = r_wait_led;
  assign btn_db   = r_btn_db;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Self-checking bench for ped_request_ctrl: directed timing scenarios plus
// randomized button/green traffic compared against a timestamp-based reference model.
module tb_ped_request_ctrl;

  localparam int DEB  = 4;
  localparam int ACK  = 4;
  localparam int HOLD = 32;

  localparam int P_IDLE  = 0;
  localparam int P_PEND  = 1;
  localparam int P_GRANT = 2;
  localparam int P_WAITG = 3;
  localparam int P_HOLD  = 4;

  logic clk;
  logic rst;
  logic btn;
  logic r_in;
  logic g_in;
  logic y_in;
  logic pass;
  logic wait_led;
  logic btn_db;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_s1, m_s2, m_db, m_db_prev, m_req, m_pass, m_wait;
  int m_ph, m_edge, m_wait_start, m_hold_start;
  bit hist[$];

  ped_request_ctrl #(
    .DEB_CYCLES    (DEB),
    .ACK_TIMEOUT   (ACK),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .R       (r_in),
    .G       (g_in),
    .Y       (y_in),
    .pass    (pass),
    .wait_led(wait_led),
    .btn_db  (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_req = 0;
    m_pass = 0; m_wait = 0; m_ph = P_IDLE; m_edge = 0;
    m_wait_start = 0; m_hold_start = 0;
    hist.delete();
  endtask

  // Debounce as a history window; FSM timing as edge-timestamp differences.
  task automatic model_step(input bit b, input bit g);
    int run;
    bit nd;
    bit press;
    bit clr;
    int nph;
    bit nreq;
    int n;
    n = m_edge;
    hist.push_back(m_s2);
    if (hist.size() > 300) hist.delete(0);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == m_db) break;
      run++;
    end
    nd    = (run >= DEB) ? ~m_db : m_db;
    press = m_db & ~m_db_prev;
    clr   = 0;
    nph   = m_ph;
    case (m_ph)
      P_IDLE:  if (m_req) nph = P_PEND;
      P_PEND:  if (g) begin clr = 1; nph = P_HOLD; m_hold_start = n; end
               else nph = P_GRANT;
      P_GRANT: begin nph = P_WAITG; m_wait_start = n; end
      P_WAITG: if (g) begin clr = 1; nph = P_HOLD; m_hold_start = n; end
               else if (n - m_wait_start >= ACK) nph = P_PEND;
      default: if (n - m_hold_start >= HOLD) nph = m_req ? P_PEND : P_IDLE;
    endcase
    nreq      = press | (m_req & ~clr);
    m_db_prev = m_db;
    m_db      = nd;
    m_s2      = m_s1;
    m_s1      = b;
    m_req     = nreq;
    m_ph      = nph;
    m_pass    = (nph == P_GRANT);
    m_wait    = (nph == P_PEND) || (nph == P_GRANT) || (nph == P_WAITG) ||
                ((nph == P_HOLD) && nreq);
    m_edge++;
  endtask

  // Drive inputs away from the edge, clock once, then compare against the model.
  task automatic step(input bit b, input bit g);
    btn  = b;
    g_in = g;
    r_in = 1'($urandom_range(0, 1));
    y_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_step(b, g);
    #1;
    check_val("pass", 32'(pass), 32'(m_pass));
    check_val("wait_led", 32'(wait_led), 32'(m_wait));
    check_val("btn_db", 32'(btn_db), 32'(m_db));
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_wait", 32'(wait_led), 32'd0);
    check_val("rst_db", 32'(btn_db), 32'd0);
    model_reset();
    btn  = 1'b0;
    g_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int first_p;
    int second_p;
    int cnt_p;
    int cnt_w;
    int max_db;
    bit b_cur;
    bit g_cur;
    int seg_left;

    rst = 1'b0; btn = 1'b0; g_in = 1'b0; r_in = 1'b1; y_in = 1'b0;
    model_reset();
    #1;
    check_val("init_pass", 32'(pass), 32'd0);
    check_val("init_wait", 32'(wait_led), 32'd0);
    check_val("init_db", 32'(btn_db), 32'd0);
    #12;
    @(negedge clk);
    rst = 1'b1;

    // Basic grant: G rises two cycles after the pass pulse
    for (int e = 0; e <= 10; e++) begin
      step(1'b1, e == 10);
      if (e == 4) check_val("basic_db_e4", 32'(btn_db), 32'd0);
      if (e == 5) check_val("basic_db_e5", 32'(btn_db), 32'd1);
      if (e == 7) check_val("basic_wait_e7", 32'(wait_led), 32'd1);
      if (e == 7) check_val("basic_pass_e7", 32'(pass), 32'd0);
      if (e == 8) check_val("basic_pass_e8", 32'(pass), 32'd1);
      if (e == 9) check_val("basic_pass_e9", 32'(pass), 32'd0);
      if (e == 10) check_val("basic_wait_e10", 32'(wait_led), 32'd0);
    end
    for (int e = 0; e < 40; e++) step(1'b0, 1'b1);

    // Reset asserted while in GRANT, then full debounce on the next press
    do_reset();
    for (int e = 0; e <= 8; e++) step(1'b1, 1'b0);
    check_val("pre_reset_pass", 32'(pass), 32'd1);
    do_reset();
    for (int e = 0; e <= 8; e++) begin
      step(1'b1, 1'b0);
      if (e == 7) check_val("post_reset_pass_e7", 32'(pass), 32'd0);
      if (e == 8) check_val("post_reset_pass_e8", 32'(pass), 32'd1);
    end

    // Already green: no pulse, one PENDING cycle of wait_led
    do_reset();
    cnt_p = 0; cnt_w = 0;
    for (int e = 0; e <= 40; e++) begin
      step(e <= 5, 1'b1);
      cnt_p += int'(pass);
      cnt_w += int'(wait_led);
      if (e == 7) check_val("green_wait_e7", 32'(wait_led), 32'd1);
    end
    check_val("green_pass_count", cnt_p, 0);
    check_val("green_wait_count", cnt_w, 1);

    // Glitch rejection: 3-cycle pulse is ignored
    do_reset();
    cnt_p = 0; max_db = 0;
    for (int e = 0; e <= 24; e++) begin
      step(e < 3, 1'b0);
      cnt_p += int'(pass);
      if (int'(btn_db) > max_db) max_db = int'(btn_db);
    end
    check_val("glitch_db", max_db, 0);
    check_val("glitch_pass", cnt_p, 0);
    // 4-cycle pulse is accepted
    do_reset();
    cnt_p = 0;
    for (int e = 0; e <= 11; e++) begin
      step(e < 4, 1'b0);
      cnt_p += int'(pass);
      if (e == 5) check_val("pulse4_db_e5", 32'(btn_db), 32'd1);
    end
    check_val("pulse4_pass", cnt_p, 1);

    // Timeout retry with G held low
    do_reset();
    first_p = -1; second_p = -1; cnt_w = 0;
    for (int e = 0; e <= 30; e++) begin
      step(1'b1, 1'b0);
      if (pass && first_p < 0) first_p = e;
      else if (pass && second_p < 0) second_p = e;
      if (e >= 7 && !wait_led) cnt_w++;
    end
    check_val("retry_first", first_p, DEB + 4);
    check_val("retry_gap", second_p - first_p, ACK + 2);
    check_val("retry_wait_drops", cnt_w, 0);

    // Hold-off: second press lands during HOLDOFF entered at edge 10
    do_reset();
    cnt_p = 0;
    for (int e = 0; e <= 50; e++) begin
      step((e <= 5) || (e >= 12 && e <= 20), e == 10);
      if (e > 10 && e < 10 + HOLD + 1) cnt_p += int'(pass);
      if (e == 17) check_val("hold_wait_e17", 32'(wait_led), 32'd0);
      if (e == 18) check_val("hold_wait_e18", 32'(wait_led), 32'd1);
      if (e == 10 + HOLD + 1) check_val("hold_pass_due", 32'(pass), 32'd1);
    end
    check_val("hold_early_pass", cnt_p, 0);

    // Randomized traffic against the reference model
    do_reset();
    b_cur = 1'b0; g_cur = 1'b0; seg_left = 5;
    for (int k = 0; k < 3000; k++) begin
      if (seg_left <= 0) begin
        b_cur    = ~b_cur;
        seg_left = b_cur ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 7) == 0) g_cur = ~g_cur;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(b_cur, g_cur);
      seg_left--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
